// File: rtl/sdram_pkg.sv
// sdram_pkg -- shared definitions for the SDRAM responder model.
//   sdram_cmd_e   : decoded SDRAM command
//   bank_state_t  : per-bank bookkeeping {open, row, trcd_cnt}
//   decode_cmd()  : CKE/CS/RAS/CAS/WE pins -> sdram_cmd_e
//   MODE_*        : mode-register field positions and reset value
package sdram_pkg;

  typedef enum logic [2:0] {
    CMD_NOP       = 3'd0,
    CMD_ACTIVE    = 3'd1,
    CMD_READ      = 3'd2,
    CMD_WRITE     = 3'd3,
    CMD_PRECHARGE = 3'd4,
    CMD_REFRESH   = 3'd5,
    CMD_LOAD_MODE = 3'd6
  } sdram_cmd_e;

  localparam int ROW_BITS       = 13;
  localparam int TRCD_CNT_BITS  = 4;
  localparam int MODE_BITS      = 10;
  localparam int MODE_CL_LSB    = 4;
  localparam int MODE_CL_MSB    = 6;
  localparam int MODE_BURST_LSB = 0;
  localparam int MODE_BURST_MSB = 2;
  // CL=2, burst length 1
  localparam logic [MODE_BITS-1:0] MODE_RESET = 10'h020;

  typedef struct packed {
    logic                     open;
    logic [ROW_BITS-1:0]      row;
    logic [TRCD_CNT_BITS-1:0] trcd_cnt;
  } bank_state_t;

  function automatic sdram_cmd_e decode_cmd(input logic cke, input logic ncs,
                                            input logic nras, input logic ncas,
                                            input logic nwe);
    sdram_cmd_e cmd;
    cmd = CMD_NOP;
    if (cke && !ncs) begin
      case ({nras, ncas, nwe})
        3'b011:  cmd = CMD_ACTIVE;
        3'b101:  cmd = CMD_READ;
        3'b100:  cmd = CMD_WRITE;
        3'b010:  cmd = CMD_PRECHARGE;
        3'b001:  cmd = CMD_REFRESH;
        3'b000:  cmd = CMD_LOAD_MODE;
        default: cmd = CMD_NOP; // NOP and BURST TERMINATE
      endcase
    end
    return cmd;
  endfunction

endpackage

// File: rtl/sdram_responder_mem.sv
// sdram_responder_mem -- single-port 16-bit backing RAM.
//   clk    : clock
//   addr   : word address (ADDR_BITS)
//   we_lo  : write enable for wdata[7:0]
//   we_hi  : write enable for wdata[15:8]
//   wdata  : write data
//   rdata  : registered read data of addr (one cycle latency)
// Contents are deliberately not reset so they survive a responder reset.
module sdram_responder_mem #(
  parameter int ADDR_BITS = 14
) (
  input  logic                 clk,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic                 we_lo,
  input  logic                 we_hi,
  input  logic [15:0]          wdata,
  output logic [15:0]          rdata
);

  logic [15:0] mem_q [0:(1<<ADDR_BITS)-1];
  logic [15:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_lo) mem_q[addr][7:0]  <= wdata[7:0];
    if (we_hi) mem_q[addr][15:8] <= wdata[15:8];
    rdata_q <= mem_q[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sdram_responder.sv
// sdram_responder -- synthesizable SDR SDRAM device model (16-bit).
//   clk, reset_n            : clock, async active-low reset
//   sdram_a/ba              : address / bank
//   sdram_ncs/nras/ncas/nwe : command strobes, sdram_cke clock enable
//   sdram_dqml/dqmh         : byte masks (1 = masked)
//   sdram_dq_in             : write data
//   sdram_dq_out/dq_oe      : read data and its drive enable
//   mode_valid              : LOAD_MODE seen since reset
//   refresh_cnt             : saturating AUTO_REFRESH count
//   proto_err               : sticky protocol-violation flag
// Optional: define SDRAM_RESPONDER_TIMING_CHECK_EN to build the protocol
// checks and tRCD counters; without it proto_err is tied low.
module sdram_responder #(
  parameter int MEM_ADDR_BITS = 14,
  parameter int COL_BITS      = 9,
  parameter int TRCD          = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [12:0] sdram_a,
  input  logic [1:0]  sdram_ba,
  input  logic        sdram_ncs,
  input  logic        sdram_nras,
  input  logic        sdram_ncas,
  input  logic        sdram_nwe,
  input  logic        sdram_cke,
  input  logic        sdram_dqml,
  input  logic        sdram_dqmh,
  input  logic [15:0] sdram_dq_in,
  output logic [15:0] sdram_dq_out,
  output logic        sdram_dq_oe,
  output logic        mode_valid,
  output logic [15:0] refresh_cnt,
  output logic        proto_err
);
  import sdram_pkg::*;

  sdram_cmd_e cmd;

  bank_state_t [3:0]      bank_q, bank_d;
  logic [MODE_BITS-1:0]   mode_q, mode_d;
  logic                   mode_valid_q, mode_valid_d;
  logic [15:0]            refresh_cnt_q, refresh_cnt_d;

  // Read pipeline. Stage 0 is aligned with the RAM's registered output;
  // stage 1 adds the extra cycle needed for CL=3.
  logic                   p0_valid_q, p0_valid_d;
  logic                   p0_cl3_q, p0_cl3_d;
  logic [1:0]             p0_dqm_q, p0_dqm_d;   // {dqmh, dqml}
  logic                   p1_valid_q, p1_valid_d;
  logic [15:0]            p1_data_q, p1_data_d;
  logic [15:0]            dq_out_q, dq_out_d;
  logic                   dq_oe_q, dq_oe_d;

  logic [MEM_ADDR_BITS-1:0] ram_addr;
  logic                     ram_we_lo, ram_we_hi;
  logic [15:0]              ram_rdata;
  logic [15:0]              rd_masked;
  logic                     cl3;

`ifdef SDRAM_RESPONDER_TIMING_CHECK_EN
  logic proto_err_q, proto_err_d;
  logic err;
  logic any_open;
`endif

  sdram_responder_mem #(.ADDR_BITS(MEM_ADDR_BITS)) u_mem (
    .clk   (clk),
    .addr  (ram_addr),
    .we_lo (ram_we_lo),
    .we_hi (ram_we_hi),
    .wdata (sdram_dq_in),
    .rdata (ram_rdata)
  );

  always_comb begin
    cmd           = decode_cmd(sdram_cke, sdram_ncs, sdram_nras, sdram_ncas, sdram_nwe);
    bank_d        = bank_q;
    mode_d        = mode_q;
    mode_valid_d  = mode_valid_q;
    refresh_cnt_d = refresh_cnt_q;
    p0_valid_d    = 1'b0;
    p0_cl3_d      = 1'b0;
    p0_dqm_d      = 2'b00;
    ram_we_lo     = 1'b0;
    ram_we_hi     = 1'b0;
    // Unsupported CL codes fall back to CL=2.
    cl3           = (mode_q[MODE_CL_MSB:MODE_CL_LSB] == 3'd3);
    // Device address {ba,row,col} folded onto the backing store.
    ram_addr      = MEM_ADDR_BITS'({sdram_ba, bank_q[sdram_ba].row,
                                    sdram_a[COL_BITS-1:0]});

`ifdef SDRAM_RESPONDER_TIMING_CHECK_EN
    err      = 1'b0;
    any_open = 1'b0;
    for (int i = 0; i < 4; i++) begin
      any_open = any_open | bank_q[i].open;
      if (bank_q[i].trcd_cnt != '0)
        bank_d[i].trcd_cnt = bank_q[i].trcd_cnt - 1'b1;
    end
`endif

    case (cmd)
      CMD_ACTIVE: begin
`ifdef SDRAM_RESPONDER_TIMING_CHECK_EN
        if (bank_q[sdram_ba].open) err = 1'b1;
        bank_d[sdram_ba].trcd_cnt = TRCD_CNT_BITS'(TRCD - 1);
`endif
        bank_d[sdram_ba].open = 1'b1;
        bank_d[sdram_ba].row  = sdram_a;
      end
      CMD_READ, CMD_WRITE: begin
`ifdef SDRAM_RESPONDER_TIMING_CHECK_EN
        if (!bank_q[sdram_ba].open || (bank_q[sdram_ba].trcd_cnt != '0) ||
            !mode_valid_q)
          err = 1'b1;
        // Our read data is on the bus while the controller drives a write.
        if ((cmd == CMD_WRITE) && dq_oe_q) err = 1'b1;
`endif
        if (cmd == CMD_WRITE) begin
          ram_we_lo = !sdram_dqml;
          ram_we_hi = !sdram_dqmh;
        end else begin
          p0_valid_d = 1'b1;
          p0_cl3_d   = cl3;
          p0_dqm_d   = {sdram_dqmh, sdram_dqml};
        end
        if (sdram_a[10]) bank_d[sdram_ba].open = 1'b0;
      end
      CMD_PRECHARGE: begin
        if (sdram_a[10]) begin
          for (int i = 0; i < 4; i++) bank_d[i].open = 1'b0;
        end else begin
          bank_d[sdram_ba].open = 1'b0;
        end
      end
      CMD_REFRESH: begin
`ifdef SDRAM_RESPONDER_TIMING_CHECK_EN
        if (any_open) err = 1'b1;
`endif
        if (refresh_cnt_q != 16'hFFFF) refresh_cnt_d = refresh_cnt_q + 16'd1;
      end
      CMD_LOAD_MODE: begin
`ifdef SDRAM_RESPONDER_TIMING_CHECK_EN
        if (sdram_a[MODE_BURST_MSB:MODE_BURST_LSB] != 3'b000) err = 1'b1;
`endif
        mode_d       = sdram_a[MODE_BITS-1:0];
        mode_valid_d = 1'b1;
      end
      default: ;
    endcase

    rd_masked = {p0_dqm_q[1] ? 8'h00 : ram_rdata[15:8],
                 p0_dqm_q[0] ? 8'h00 : ram_rdata[7:0]};
    p1_valid_d = p0_valid_q && p0_cl3_q;
    p1_data_d  = rd_masked;

    // The bus is only driven for one cycle per read; idle value is zero.
    if (p1_valid_q) begin
      dq_out_d = p1_data_q;
      dq_oe_d  = 1'b1;
    end else if (p0_valid_q && !p0_cl3_q) begin
      dq_out_d = rd_masked;
      dq_oe_d  = 1'b1;
    end else begin
      dq_out_d = 16'h0000;
      dq_oe_d  = 1'b0;
    end

`ifdef SDRAM_RESPONDER_TIMING_CHECK_EN
    proto_err_d = proto_err_q | err;
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bank_q        <= '0;
      mode_q        <= MODE_RESET;
      mode_valid_q  <= 1'b0;
      refresh_cnt_q <= 16'h0000;
      p0_valid_q    <= 1'b0;
      p0_cl3_q      <= 1'b0;
      p0_dqm_q      <= 2'b00;
      p1_valid_q    <= 1'b0;
      p1_data_q     <= 16'h0000;
      dq_out_q      <= 16'h0000;
      dq_oe_q       <= 1'b0;
`ifdef SDRAM_RESPONDER_TIMING_CHECK_EN
      proto_err_q   <= 1'b0;
`endif
    end else begin
      bank_q        <= bank_d;
      mode_q        <= mode_d;
      mode_valid_q  <= mode_valid_d;
      refresh_cnt_q <= refresh_cnt_d;
      p0_valid_q    <= p0_valid_d;
      p0_cl3_q      <= p0_cl3_d;
      p0_dqm_q      <= p0_dqm_d;
      p1_valid_q    <= p1_valid_d;
      p1_data_q     <= p1_data_d;
      dq_out_q      <= dq_out_d;
      dq_oe_q       <= dq_oe_d;
`ifdef SDRAM_RESPONDER_TIMING_CHECK_EN
      proto_err_q   <= proto_err_d;
`endif
    end
  end

  assign sdram_dq_out = dq_out_q;
  assign sdram_dq_oe  = dq_oe_q;
  assign mode_valid   = mode_valid_q;
  assign refresh_cnt  = refresh_cnt_q;
`ifdef SDRAM_RESPONDER_TIMING_CHECK_EN
  assign proto_err    = proto_err_q;
`else
  assign proto_err    = 1'b0;
`endif

endmodule
